// File: rtl/absmem_rd_if.sv
// Bus bundle for the read-side abstract memory: issue/compare control, the two read ports and
// the check results.
interface absmem_rd_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          issue;
    logic          compare;
    logic [AW-1:0] vlg_raddr;
    logic          vlg_ren;
    logic [DW-1:0] vlg_rdata;
    logic [DW-1:0] vlg_r_rand_input;
    logic [AW-1:0] ila_raddr;
    logic          ila_ren;
    logic [DW-1:0] ila_rdata;
    logic [DW-1:0] ila_r_rand_input;
    logic          equal;
    logic          overflow;

    modport master (
        output issue, compare,
        output vlg_raddr, vlg_ren, vlg_r_rand_input,
        output ila_raddr, ila_ren, ila_r_rand_input,
        input  vlg_rdata, ila_rdata, equal, overflow
    );

    modport slave (
        input  issue, compare,
        input  vlg_raddr, vlg_ren, vlg_r_rand_input,
        input  ila_raddr, ila_ren, ila_r_rand_input,
        output vlg_rdata, ila_rdata, equal, overflow
    );
endinterface

// File: rtl/absmem_rd.sv
// Read-side abstract memory shared by the Verilog and ILA models: first read of an address returns
// a free value, later reads return the same value; read-address sequences are compared at the end.
module absmem_rd #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input logic        clk,
    input logic        rst,
    absmem_rd_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             armed_q, armed_d;
    logic             overflow_q, overflow_d;

    logic [DEPTH-1:0] tab_valid_q, tab_valid_d;
    logic [AW-1:0]    tab_addr_q [DEPTH];
    logic [AW-1:0]    tab_addr_d [DEPTH];
    logic [DW-1:0]    tab_data_q [DEPTH];
    logic [DW-1:0]    tab_data_d [DEPTH];

    logic [AW-1:0]    vlg_log_q [DEPTH];
    logic [AW-1:0]    vlg_log_d [DEPTH];
    logic [AW-1:0]    ila_log_q [DEPTH];
    logic [AW-1:0]    ila_log_d [DEPTH];
    logic [CW-1:0]    vlg_cnt_q, vlg_cnt_d;
    logic [CW-1:0]    ila_cnt_q, ila_cnt_d;

    logic             vlg_ren_real, ila_ren_real;
    logic             vlg_hit, ila_hit;
    logic [DW-1:0]    vlg_hit_data, ila_hit_data;
    logic             vlg_miss, ila_miss;
    logic             shared_miss;
    logic             ila_alloc;
    logic [DEPTH-1:0] free0_oh, free1_oh, ila_slot_oh;
    logic             found0, found1;
    logic             tab_ovf, vlg_log_ovf, ila_log_ovf;
    logic             logs_match;

    assign vlg_ren_real = bus.vlg_ren & ~bus.compare & armed_q;
    assign ila_ren_real = bus.ila_ren & ~bus.compare & armed_q;

    always_comb begin
        vlg_hit      = 1'b0;
        ila_hit      = 1'b0;
        vlg_hit_data = '0;
        ila_hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (tab_valid_q[i] && tab_addr_q[i] == bus.vlg_raddr) begin
                vlg_hit      = 1'b1;
                vlg_hit_data = tab_data_q[i];
            end
            if (tab_valid_q[i] && tab_addr_q[i] == bus.ila_raddr) begin
                ila_hit      = 1'b1;
                ila_hit_data = tab_data_q[i];
            end
        end
    end

    assign vlg_miss    = vlg_ren_real & ~vlg_hit;
    assign ila_miss    = ila_ren_real & ~ila_hit;
    // Simultaneous misses on one address share the Verilog free value and a single entry.
    assign shared_miss = vlg_miss & ila_miss & (bus.vlg_raddr == bus.ila_raddr);
    assign ila_alloc   = ila_miss & ~shared_miss;

    assign bus.vlg_rdata = (vlg_ren_real && vlg_hit) ? vlg_hit_data : bus.vlg_r_rand_input;
    assign bus.ila_rdata = (ila_ren_real && ila_hit) ? ila_hit_data :
                           shared_miss               ? bus.vlg_r_rand_input :
                                                       bus.ila_r_rand_input;

    always_comb begin
        free0_oh = '0;
        free1_oh = '0;
        found0   = 1'b0;
        found1   = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!tab_valid_q[i]) begin
                if (!found0) begin
                    free0_oh[i] = 1'b1;
                    found0      = 1'b1;
                end else if (!found1) begin
                    free1_oh[i] = 1'b1;
                    found1      = 1'b1;
                end
            end
        end
    end

    // When Verilog allocates, ILA takes the next free entry.
    assign ila_slot_oh = vlg_miss ? free1_oh : free0_oh;

    always_comb begin
        tab_valid_d = tab_valid_q;
        tab_addr_d  = tab_addr_q;
        tab_data_d  = tab_data_q;
        tab_ovf     = 1'b0;
        if (vlg_miss) begin
            if (|free0_oh) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (free0_oh[i]) begin
                        tab_valid_d[i] = 1'b1;
                        tab_addr_d[i]  = bus.vlg_raddr;
                        tab_data_d[i]  = bus.vlg_r_rand_input;
                    end
                end
            end else begin
                tab_ovf = 1'b1;
            end
        end
        if (ila_alloc) begin
            if (|ila_slot_oh) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (ila_slot_oh[i]) begin
                        tab_valid_d[i] = 1'b1;
                        tab_addr_d[i]  = bus.ila_raddr;
                        tab_data_d[i]  = bus.ila_r_rand_input;
                    end
                end
            end else begin
                tab_ovf = 1'b1;
            end
        end
    end

    always_comb begin
        vlg_log_d   = vlg_log_q;
        vlg_cnt_d   = vlg_cnt_q;
        vlg_log_ovf = 1'b0;
        if (vlg_ren_real) begin
            if (vlg_cnt_q < CW'(DEPTH)) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == vlg_cnt_q) vlg_log_d[i] = bus.vlg_raddr;
                end
                vlg_cnt_d = vlg_cnt_q + CW'(1);
            end else begin
                vlg_log_ovf = 1'b1;
            end
        end
    end

    always_comb begin
        ila_log_d   = ila_log_q;
        ila_cnt_d   = ila_cnt_q;
        ila_log_ovf = 1'b0;
        if (ila_ren_real) begin
            if (ila_cnt_q < CW'(DEPTH)) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == ila_cnt_q) ila_log_d[i] = bus.ila_raddr;
                end
                ila_cnt_d = ila_cnt_q + CW'(1);
            end else begin
                ila_log_ovf = 1'b1;
            end
        end
    end

    assign armed_d    = armed_q | bus.issue;
    assign overflow_d = overflow_q | tab_ovf | vlg_log_ovf | ila_log_ovf;

    always_comb begin
        logs_match = (vlg_cnt_q == ila_cnt_q);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < vlg_cnt_q && vlg_log_q[i] != ila_log_q[i]) logs_match = 1'b0;
        end
    end

    assign bus.equal    = bus.compare & ~overflow_q & logs_match;
    assign bus.overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q     <= 1'b0;
            overflow_q  <= 1'b0;
            tab_valid_q <= '0;
            vlg_cnt_q   <= '0;
            ila_cnt_q   <= '0;
        end else begin
            armed_q     <= armed_d;
            overflow_q  <= overflow_d;
            tab_valid_q <= tab_valid_d;
            vlg_cnt_q   <= vlg_cnt_d;
            ila_cnt_q   <= ila_cnt_d;
        end
    end

    // Payload arrays are qualified by valid bits and counts, so they need no reset.
    always_ff @(posedge clk) begin
        tab_addr_q <= tab_addr_d;
        tab_data_q <= tab_data_d;
        vlg_log_q  <= vlg_log_d;
        ila_log_q  <= ila_log_d;
    end
endmodule

// File: tb/tb_absmem_rd.sv
// Randomized and directed checks of absmem_rd against a map/queue reference model.
module tb_absmem_rd;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    absmem_rd_if #(.AW(AW), .DW(DW)) bus ();

    absmem_rd #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: address->value map plus per-side read-address queues.
    logic [7:0] m_mem [logic [7:0]];
    logic [7:0] m_vq [$];
    logic [7:0] m_iq [$];
    logic       m_armed;
    logic       m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_mem.delete();
        m_vq.delete();
        m_iq.delete();
        m_armed = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock cycle: drive after the edge, check mid-cycle, then advance the model.
    task automatic cyc(input logic r, input logic is, input logic cm,
                       input logic ve, input logic [7:0] va, input logic [7:0] vr,
                       input logic ie, input logic [7:0] ia, input logic [7:0] ir);
        logic vreal, ireal, vhit, ihit, shared, eq;
        logic [7:0] exp_v, exp_i;
        @(posedge clk);
        #1;
        rst                  = r;
        bus.issue            = is;
        bus.compare          = cm;
        bus.vlg_ren          = ve;
        bus.vlg_raddr        = va;
        bus.vlg_r_rand_input = vr;
        bus.ila_ren          = ie;
        bus.ila_raddr        = ia;
        bus.ila_r_rand_input = ir;
        @(negedge clk);
        vreal  = ve && !cm && m_armed;
        ireal  = ie && !cm && m_armed;
        vhit   = vreal && m_mem.exists(va);
        ihit   = ireal && m_mem.exists(ia);
        shared = vreal && !vhit && ireal && !ihit && (va == ia);
        exp_v  = vhit ? m_mem[va] : vr;
        exp_i  = ihit ? m_mem[ia] : (shared ? vr : ir);
        eq     = cm && !m_ovf && (m_vq.size() == m_iq.size());
        for (int i = 0; i < m_vq.size() && i < m_iq.size(); i++)
            if (m_vq[i] != m_iq[i]) eq = 1'b0;
        check("vlg_rdata", 32'(bus.vlg_rdata), 32'(exp_v));
        check("ila_rdata", 32'(bus.ila_rdata), 32'(exp_i));
        check("equal", 32'(bus.equal), 32'(eq));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (r) begin
            model_clear();
        end else begin
            if (vreal && !vhit) begin
                if (m_mem.num() < DEPTH) m_mem[va] = vr;
                else m_ovf = 1'b1;
            end
            if (ireal && !ihit && !shared) begin
                if (m_mem.num() < DEPTH) m_mem[ia] = ir;
                else m_ovf = 1'b1;
            end
            if (vreal) begin
                if (m_vq.size() < DEPTH) m_vq.push_back(va);
                else m_ovf = 1'b1;
            end
            if (ireal) begin
                if (m_iq.size() < DEPTH) m_iq.push_back(ia);
                else m_ovf = 1'b1;
            end
            m_armed = m_armed | is;
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic restart();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_compare();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        logic       mirror, pv_en, ve, ie;
        logic [7:0] pv_addr, va, ia;
        model_clear();
        rst = 1'b1;
        bus.issue = 1'b0;
        bus.compare = 1'b0;
        bus.vlg_ren = 1'b0;
        bus.vlg_raddr = '0;
        bus.vlg_r_rand_input = '0;
        bus.ila_ren = 1'b0;
        bus.ila_raddr = '0;
        bus.ila_r_rand_input = '0;

        // Not armed: reads pass the free value through and are not logged.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        check("reset_overflow", 32'(bus.overflow), 32'h0);
        check("reset_equal", 32'(bus.equal), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'hAA, 1'b0, 8'h00, 8'h00);
        check("unarmed_rdata", 32'(bus.vlg_rdata), 32'hAA);
        do_compare();
        check("unarmed_equal", 32'(bus.equal), 32'h1);

        // Later ILA read of the same address sees the Verilog free value.
        restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h5C, 1'b0, 8'h00, 8'h00);
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h33);
        check("ila_hit", 32'(bus.ila_rdata), 32'h5C);
        do_compare();
        check("seq_equal", 32'(bus.equal), 32'h1);

        // Simultaneous miss on one address uses one entry.
        restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h01, 1'b1, 8'h20, 8'h02);
        check("shared_vlg", 32'(bus.vlg_rdata), 32'h01);
        check("shared_ila", 32'(bus.ila_rdata), 32'h01);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 8'h09, 1'b0, 8'h00, 8'h00);
        idle();
        check("one_entry_used", 32'(bus.overflow), 32'h0);

        // Swapped order must not compare equal.
        restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h11, 1'b1, 8'h21, 8'h22);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 8'h33, 1'b1, 8'h20, 8'h44);
        do_compare();
        check("order_equal", 32'(bus.equal), 32'h0);

        // Third distinct miss overflows the 2-entry table.
        restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'hA1, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 8'hA2, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'hA3, 1'b0, 8'h00, 8'h00);
        do_compare();
        check("ovf_set", 32'(bus.overflow), 32'h1);
        check("ovf_equal", 32'(bus.equal), 32'h0);

        // Reset clears the table.
        restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 8'h77, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 8'h99, 1'b0, 8'h00, 8'h00);
        check("pre_reset_hit", 32'(bus.vlg_rdata), 32'h77);
        restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 8'h12, 1'b0, 8'h00, 8'h00);
        check("post_reset_miss", 32'(bus.vlg_rdata), 32'h12);

        // Random instructions; half of them have ILA replay the Verilog reads one cycle late.
        for (int n = 0; n < 60; n++) begin
            restart();
            mirror  = 1'($urandom_range(0, 1));
            pv_en   = 1'b0;
            pv_addr = 8'h00;
            for (int c = 0; c < 9; c++) begin
                ve = (c < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
                va = 8'h50 + 8'($urandom_range(0, 2));
                if (mirror) begin
                    ie = pv_en;
                    ia = pv_addr;
                end else begin
                    ie = 1'($urandom_range(0, 1));
                    ia = 8'h50 + 8'($urandom_range(0, 2));
                end
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, ve, va, 8'($urandom),
                    ie, ia, 8'($urandom));
                pv_en   = ve;
                pv_addr = va;
            end
            do_compare();
            // Reads under compare are frozen.
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h52, 8'($urandom), 1'b1, 8'h51, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
